credit_rx_buffer: RTL

CREDIT_RX_BUFFER -- requirements
Module: credit_rx_buffer

---
 rtl/credit_rx_buffer_if.sv | 36 +++
 rtl/credit_rx_buffer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/credit_rx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : credit_rx_buffer_if
// Description : Link-side and crossbar-side signal bundle for credit_rx_buffer.
//               The master modport is the link/crossbar side that drives
//               flits and pops. The slave modport is the buffer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface credit_rx_buffer_if #(
  parameter int NUM_VCS = 2,
  parameter int FLIT_W  = 8
);
  localparam int VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  typedef logic [FLIT_W-1:0] flit_t;

  flit_t                            in_flit;
  logic                             in_valid;
  logic [VC_W-1:0]                  in_vc;
  logic [NUM_VCS-1:0][FLIT_W-1:0]   out_flit;
  logic [NUM_VCS-1:0]               empty;
  logic [NUM_VCS-1:0]               pop;
  logic [NUM_VCS-1:0]               credit_granted;
  logic                             overflow;

  modport master (
    output in_flit, in_valid, in_vc, pop,
    input  out_flit, empty, credit_granted, overflow
  );

  modport slave (
    input  in_flit, in_valid, in_vc, pop,
    output out_flit, empty, credit_granted, overflow
  );
endinterface
`default_nettype wire

// File: rtl/credit_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : credit_rx_buffer
// Description : Per-VC receive FIFOs for a credit-based link. Every
//               CREDIT_BATCH effective pops on a VC return one registered
//               credit pulse to the upstream sender.
//               Optional feature macro: CREDIT_RX_OVERFLOW_CHECK_EN enables
//               the sticky overflow flag. Without it, overflow is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_rx_buffer #(
  parameter int NUM_VCS      = 2,
  parameter int BUFFER_SIZE  = 8,
  parameter int CREDIT_BATCH = 3*BUFFER_SIZE/4,
  parameter int FLIT_W       = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  credit_rx_buffer_if.slave     bus
);
  localparam int VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  typedef logic [FLIT_W-1:0] flit_t;

  // Pushes to a full VC that had no same-cycle pop to make room.
  logic [NUM_VCS-1:0] drop_vec;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    flit_t            mem_q [BUFFER_SIZE];
    flit_t            mem_d [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] freed_q, freed_d;
    logic             credit_q, credit_d;

    logic sel, full, pop_eff, push_eff;

    assign sel      = bus.in_valid && (bus.in_vc == VC_W'(v));
    assign full     = (count_q == CNT_W'(BUFFER_SIZE));
    assign pop_eff  = bus.pop[v] && (count_q != '0);
    // A pop on a full VC frees the slot in the same cycle, so push still lands.
    assign push_eff = sel && (!full || pop_eff);
    assign drop_vec[v] = sel && full && !pop_eff;

    assign bus.out_flit[v]       = mem_q[rd_ptr_q];
    assign bus.empty[v]          = (count_q == '0);
    assign bus.credit_granted[v] = credit_q;

    // Next-state for pointers, occupancy, freed counter and credit pulse.
    always_comb begin
      wr_ptr_d = push_eff ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_eff  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push_eff && !pop_eff) begin
        count_d = count_q + 1'b1;
      end else if (!push_eff && pop_eff) begin
        count_d = count_q - 1'b1;
      end
      freed_d  = freed_q;
      credit_d = 1'b0;
      if (pop_eff) begin
        if (freed_q + 1'b1 == CNT_W'(CREDIT_BATCH)) begin
          freed_d  = '0;
          credit_d = 1'b1;
        end else begin
          freed_d  = freed_q + 1'b1;
        end
      end
    end

    // Next-state for the storage array: write the incoming flit at the write pointer.
    always_comb begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        mem_d[i] = mem_q[i];
      end
      if (push_eff) begin
        mem_d[wr_ptr_q] = bus.in_flit;
      end
    end

    // Control state with asynchronous clear; contents are discarded on reset.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        freed_q  <= '0;
        credit_q <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        freed_q  <= freed_d;
        credit_q <= credit_d;
      end
    end

    // Flit storage needs no reset: the occupancy count qualifies every entry.
    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end
  end

`ifdef CREDIT_RX_OVERFLOW_CHECK_EN
  logic overflow_q, overflow_d;

  // Overflow latches on the first dropped push and holds until reset.
  always_comb begin
    overflow_d = overflow_q | (|drop_vec);
  end

  // Sticky overflow flag register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`else
  logic unused_drop;
  assign unused_drop  = |drop_vec;
  assign bus.overflow = 1'b0;
`endif

endmodule
`default_nettype wire
